pipelined_carry_select_adder: RTL

Parametrised, pipelined carry-select adder/subtractor. It is the throughput-oriented successor to the 16-bit combinational carry-select adder.
- The operand is split into NUM_BLOCKS = WIDTH/BLOCK slices, with one slice resolved per pipeline stage.
- Each stage precomputes carry-in=0 and carry-in=1 candidates and selects between them with the registered carry from the previous stage.
- A valid/ready stream interface on both sides allows the block to sit in datapaths with backpressure.

---
 rtl/pipelined_carry_select_adder.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit slice resolved per stage,
// with a valid/ready stream on both sides and a global hold on downstream backpressure.
module pipelined_carry_select_adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             c_out,
   output logic             overflow
);

   localparam int NUM_BLOCKS = (WIDTH / BLOCK < 1) ? 1 : WIDTH / BLOCK;
   localparam int LAST       = NUM_BLOCKS - 1;

   // Handshake: a beat moves on a rising edge where valid && ready. The output side
   // stalls when out_valid && !out_ready; the whole pipe then holds and in_ready drops.
   logic stall;
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   logic [WIDTH-1:0] eff_b;
   logic             eff_cin;
   assign eff_b   = sub ? ~b : b;
   assign eff_cin = sub ? ~c_in : c_in;

   // Stage inputs (combinational) and stage registers
   logic [WIDTH-1:0] stg_a [NUM_BLOCKS];
   logic [WIDTH-1:0] stg_b [NUM_BLOCKS];
   logic [WIDTH-1:0] stg_s [NUM_BLOCKS];
   logic             stg_c [NUM_BLOCKS];
   logic             stg_v [NUM_BLOCKS];
   logic [WIDTH-1:0] s_nxt [NUM_BLOCKS];
   logic             c_nxt [NUM_BLOCKS];

   logic [WIDTH-1:0] a_q   [NUM_BLOCKS];
   logic [WIDTH-1:0] b_q   [NUM_BLOCKS];
   logic [WIDTH-1:0] s_q   [NUM_BLOCKS];
   logic             c_q   [NUM_BLOCKS];
   logic             v_q   [NUM_BLOCKS];
   logic             ovf_q;
   logic             ovf_nxt;

   for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign stg_a[k] = a;
         assign stg_b[k] = eff_b;
         assign stg_s[k] = '0;
         assign stg_c[k] = eff_cin;
         assign stg_v[k] = in_valid;
      end else begin : g_tail
         assign stg_a[k] = a_q[k-1];
         assign stg_b[k] = b_q[k-1];
         assign stg_s[k] = s_q[k-1];
         assign stg_c[k] = c_q[k-1];
         assign stg_v[k] = v_q[k-1];
      end

      logic [BLOCK:0]   cand0;
      logic [BLOCK:0]   cand1;
      logic [BLOCK:0]   pick;
      logic [WIDTH-1:0] sum_sel;

      // Both carry-in candidates are formed up front; the incoming carry only muxes.
      assign cand0 = {1'b0, stg_a[k][k*BLOCK +: BLOCK]} + {1'b0, stg_b[k][k*BLOCK +: BLOCK]};
      assign cand1 = cand0 + {{BLOCK{1'b0}}, 1'b1};
      assign pick  = stg_c[k] ? cand1 : cand0;

      always_comb begin
         sum_sel = stg_s[k];
         sum_sel[k*BLOCK +: BLOCK] = pick[BLOCK-1:0];
      end

      assign s_nxt[k] = sum_sel;
      assign c_nxt[k] = pick[BLOCK];
   end

   // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
   assign ovf_nxt = stg_a[LAST][WIDTH-1] ^ stg_b[LAST][WIDTH-1]
                  ^ s_nxt[LAST][WIDTH-1] ^ c_nxt[LAST];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_BLOCKS; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < NUM_BLOCKS; k++) begin
            a_q[k] <= stg_a[k];
            b_q[k] <= stg_b[k];
            s_q[k] <= s_nxt[k];
            c_q[k] <= c_nxt[k];
            v_q[k] <= stg_v[k];
         end
         ovf_q <= ovf_nxt;
      end
   end

   assign out_valid = v_q[LAST];
   assign out       = s_q[LAST];
   assign c_out     = c_q[LAST];
   assign overflow  = ovf_q;

endmodule
